// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall controller bundle: ID/EX hazard sources in,
// pipeline-register stall, bubble and flush enables out.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_reg_s;
  logic [4:0]       id_reg_t;
  logic             id_uses_t;
  logic [4:0]       ex_regD;
  logic             ex_MemRead;
  logic             mem_access;
  logic             dcache_ready;
  logic             icache_ready;
  logic             branch_taken_ex;
  logic             stall_if;
  logic             stall_id;
  logic             bubble_ex;
  logic             bubble_id;
  logic             freeze_mem;
  logic             flush_if;
  logic             flush_id;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_reg_s, id_reg_t, id_uses_t,
    output ex_regD, ex_MemRead, mem_access,
    output dcache_ready, icache_ready,
    output branch_taken_ex,
    input  stall_if, stall_id, bubble_ex,
    input  bubble_id, freeze_mem,
    input  flush_if, flush_id, stall_cycles
  );

  modport slave (
    input  id_reg_s, id_reg_t, id_uses_t,
    input  ex_regD, ex_MemRead, mem_access,
    input  dcache_ready, icache_ready,
    input  branch_taken_ex,
    output stall_if, stall_id, bubble_ex,
    output bubble_id, freeze_mem,
    output flush_if, flush_id, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / cache-miss / branch hazard FSM with Mealy outputs.
// HAZARD_PERF_CNT_EN enables the saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic              clk,
  input logic              reset,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN, LOAD_USE, DC_WAIT, IC_WAIT
  } state_e;

  localparam logic [2:0] LU_LOAD =
    3'(LU_STALL_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;

  logic lu, dm, run_rules;
  logic st_if, st_id, bub_ex, bub_id;
  logic frz, fl_if, fl_id;

  assign dm = bus.mem_access & ~bus.dcache_ready;

  assign lu = bus.ex_MemRead
            & (bus.ex_regD != 5'd0)
            & ((bus.ex_regD == bus.id_reg_s)
            | (bus.id_uses_t
            & (bus.ex_regD == bus.id_reg_t)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    run_rules = 1'b0;
    st_if     = 1'b0;
    st_id     = 1'b0;
    bub_ex    = 1'b0;
    bub_id    = 1'b0;
    frz       = 1'b0;
    fl_if     = 1'b0;
    fl_id     = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dm) begin
          st_if   = 1'b1;
          st_id   = 1'b1;
          frz     = 1'b1;
          state_d = DC_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      LOAD_USE: begin
        if (dm) begin
          st_if    = 1'b1;
          st_id    = 1'b1;
          frz      = 1'b1;
          state_d  = DC_WAIT;
          lu_cnt_d = '0;
        end else begin
          st_if    = 1'b1;
          st_id    = 1'b1;
          bub_ex   = 1'b1;
          lu_cnt_d = lu_cnt_q - 3'd1;
          if (lu_cnt_q <= 3'd1) state_d = RUN;
        end
      end
      DC_WAIT: begin
        if (!bus.dcache_ready) begin
          st_if = 1'b1;
          st_id = 1'b1;
          frz   = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      IC_WAIT: begin
        if (dm) begin
          st_if   = 1'b1;
          st_id   = 1'b1;
          frz     = 1'b1;
          state_d = DC_WAIT;
        end else if (bus.branch_taken_ex) begin
          st_if = 1'b1;
          fl_if = 1'b1;
          fl_id = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Shared by RUN, the D-miss release cycle and I-miss exit
    if (run_rules) begin
      if (bus.branch_taken_ex) begin
        fl_if   = 1'b1;
        fl_id   = 1'b1;
        state_d = RUN;
      end else if (lu) begin
        st_if  = 1'b1;
        st_id  = 1'b1;
        bub_ex = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          lu_cnt_d = LU_LOAD;
          state_d  = LOAD_USE;
        end else begin
          state_d = RUN;
        end
      end else if (!bus.icache_ready) begin
        st_if   = 1'b1;
        bub_id  = 1'b1;
        state_d = IC_WAIT;
      end else begin
        state_d = RUN;
      end
    end
  end

  assign bus.stall_if   = st_if  & ~reset;
  assign bus.stall_id   = st_id  & ~reset;
  assign bus.bubble_ex  = bub_ex & ~reset;
  assign bus.bubble_id  = bub_id & ~reset;
  assign bus.freeze_mem = frz    & ~reset;
  assign bus.flush_if   = fl_if  & ~reset;
  assign bus.flush_id   = fl_id  & ~reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bus.stall_if && !(&perf_q))
      perf_d = perf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bus.stall_cycles = reset ? '0 : perf_q;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: two DUTs (1 and 3 load-use bubbles) share one
// random/directed stimulus stream, checked against a behavioural model.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] s_reg, t_reg, d_reg;
  logic       uses_t, mrd, macc, drdy, irdy, br;

  hazard_stall_unit_if #(.CNT_W(16)) if1 ();
  hazard_stall_unit_if #(.CNT_W(4))  if3 ();

  assign if1.id_reg_s        = s_reg;
  assign if1.id_reg_t        = t_reg;
  assign if1.id_uses_t       = uses_t;
  assign if1.ex_regD         = d_reg;
  assign if1.ex_MemRead      = mrd;
  assign if1.mem_access      = macc;
  assign if1.dcache_ready    = drdy;
  assign if1.icache_ready    = irdy;
  assign if1.branch_taken_ex = br;
  assign if3.id_reg_s        = s_reg;
  assign if3.id_reg_t        = t_reg;
  assign if3.id_uses_t       = uses_t;
  assign if3.ex_regD         = d_reg;
  assign if3.ex_MemRead      = mrd;
  assign if3.mem_access      = macc;
  assign if3.dcache_ready    = drdy;
  assign if3.icache_ready    = irdy;
  assign if3.branch_taken_ex = br;

  hazard_stall_unit #(.LU_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(rst), .bus(if1.slave));
  hazard_stall_unit #(.LU_STALL_CYCLES(3), .CNT_W(4)) u3 (
    .clk(clk), .reset(rst), .bus(if3.slave));

  // flags = {stall_if,stall_id,bubble_ex,bubble_id,freeze_mem,flush_if,flush_id}
  localparam logic [6:0] FRZ  = 7'b1100100;
  localparam logic [6:0] LUB  = 7'b1110000;
  localparam logic [6:0] IMB  = 7'b1001000;
  localparam logic [6:0] FLS  = 7'b0000011;
  localparam logic [6:0] STIF = 7'b1000000;

  typedef struct {
    logic [6:0] f;
    int         c;
    string      tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int errs   = 0;
  int checks = 0;

  // Behavioural model state per instance
  int lu_n[2]  = '{1, 3};
  int cmax[2]  = '{65535, 15};
  int lu_left[2];
  bit dwait[2];
  bit iwait[2];
  int perf[2];

  function automatic exp_t model(int k, string tag);
    exp_t e;
    bit dm, lu;
    e.f = '0;
    e.c = 0;
    e.tag = tag;
    dm = macc && !drdy;
    lu = mrd && d_reg != 0 &&
         (d_reg == s_reg || (uses_t && d_reg == t_reg));
    if (rst) begin
      lu_left[k] = 0;
      dwait[k] = 0;
      iwait[k] = 0;
      perf[k] = 0;
      return e;
    end
    e.c = perf[k];
    if (dwait[k] && !drdy) begin
      e.f = FRZ;
    end else if (lu_left[k] > 0) begin
      if (dm) begin
        e.f = FRZ;
        dwait[k] = 1;
        lu_left[k] = 0;
      end else begin
        e.f = LUB;
        lu_left[k]--;
      end
    end else begin
      dwait[k] = 0;
      if (dm) begin
        e.f = FRZ;
        dwait[k] = 1;
        iwait[k] = 0;
      end else if (br) begin
        e.f = iwait[k] ? (FLS | STIF) : FLS;
      end else if (lu) begin
        e.f = LUB;
        lu_left[k] = lu_n[k] - 1;
        iwait[k] = 0;
      end else if (!irdy) begin
        e.f = IMB;
        iwait[k] = 1;
      end else begin
        iwait[k] = 0;
      end
    end
`ifdef HAZARD_PERF_CNT_EN
    if (e.f[6] && perf[k] < cmax[k]) perf[k]++;
`else
    e.c = 0;
`endif
    return e;
  endfunction

  task automatic idle();
    rst = 0; mrd = 0; macc = 0; drdy = 1;
    irdy = 1; br = 0; uses_t = 0;
    s_reg = 5'd1; t_reg = 5'd2; d_reg = 5'd3;
  endtask

  task automatic tick(string tag);
    q0.push_back(model(0, tag));
    q1.push_back(model(1, tag));
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int k, logic [6:0] af, int ac, exp_t e);
    checks++;
    if (af !== e.f || ac != e.c) begin
      errs++;
      $display("FAIL %s lu%0d: got flags=%b cyc=%0d, want flags=%b cyc=%0d",
               e.tag, lu_n[k], af, ac, e.f, e.c);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk(0, {if1.stall_if, if1.stall_id, if1.bubble_ex,
              if1.bubble_id, if1.freeze_mem, if1.flush_if,
              if1.flush_id}, int'(if1.stall_cycles), e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk(1, {if3.stall_if, if3.stall_id, if3.bubble_ex,
              if3.bubble_id, if3.freeze_mem, if3.flush_if,
              if3.flush_id}, int'(if3.stall_cycles), e);
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    tick("reset");
    tick("reset");
    idle();
    tick("idle");

    // load-use on rs
    mrd = 1; d_reg = 5'd5; s_reg = 5'd5;
    tick("lu_rs");
    idle();
    repeat (4) tick("lu_rs_after");

    // load-use on rt
    mrd = 1; d_reg = 5'd7; t_reg = 5'd7; uses_t = 1;
    tick("lu_rt");
    idle();
    repeat (4) tick("lu_rt_after");

    // r0 destination never stalls
    mrd = 1; d_reg = 5'd0; s_reg = 5'd0;
    t_reg = 5'd0; uses_t = 1;
    repeat (2) tick("lu_r0");
    idle();

    // D-miss with branch pulse mid-miss
    macc = 1; drdy = 0;
    tick("dmiss");
    br = 1;
    tick("dmiss_br");
    br = 0;
    repeat (2) tick("dmiss");
    drdy = 1;
    tick("dmiss_rel");
    idle();
    tick("dmiss_after");

    // branch beats load-use
    mrd = 1; d_reg = 5'd9; s_reg = 5'd9; br = 1;
    tick("br_prio");
    idle();
    repeat (3) tick("br_after");

    // I-miss then D-miss
    irdy = 0;
    tick("imiss1");
    macc = 1; drdy = 0;
    tick("imiss2_dm");
    irdy = 1;
    tick("dwait");
    drdy = 1;
    tick("dwait_rel");
    idle();
    tick("idle");

    // reset mid D-miss
    macc = 1; drdy = 0;
    repeat (2) tick("pre_rst");
    rst = 1;
    tick("rst_mid");
    idle();
    repeat (2) tick("post_rst");

    // long I-miss saturates the narrow counter
    irdy = 0;
    repeat (20) tick("sat");
    idle();
    repeat (2) tick("sat_after");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst    = ($urandom_range(0, 99) < 2);
      s_reg  = 5'($urandom_range(0, 3));
      t_reg  = 5'($urandom_range(0, 3));
      d_reg  = 5'($urandom_range(0, 3));
      uses_t = 1'($urandom_range(0, 1));
      mrd    = ($urandom_range(0, 99) < 35);
      macc   = ($urandom_range(0, 99) < 30);
      drdy   = ($urandom_range(0, 99) < 60);
      irdy   = ($urandom_range(0, 99) < 70);
      br     = ($urandom_range(0, 99) < 15);
      tick("rand");
    end
    idle();
    tick("final");

    repeat (2) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0",
               q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
